// File: rtl/lsu_mem_if_if.sv
// Word-wide data-memory bus between the load/store unit (master) and memory (slave).
// Single-cycle ack strobe; rdata is only meaningful while ack is high.
interface lsu_mem_if_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store unit: turns datapath loads/stores into req/ack bus transactions,
// stalling the core until done, with alignment checks and a bus timeout.
module lsu_mem_if #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  lsu_mem_if_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [1:0]  off_q, size_q;
  logic        uns_q;
  logic [31:0] rdata_q;
  logic        req_q, we_q, err_q;
  logic [31:0] baddr_q, bwdata_q;
  logic [3:0]  be_q;

  logic        access, go, is_half, is_word, tmo;
  logic [3:0]  be_d;
  logic [31:0] lanes_d, ld_ext;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign access  = mem_read | mem_write;
  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = funct3[1];
  assign go      = access & ~misaligned;
  assign tmo     = (cnt_q == 8'(TIMEOUT - 1));

  // Lane steering for stores: replicate so the slave can pick any lane by be.
  always_comb begin
    be_d    = 4'b1111;
    lanes_d = wdata;
    if (is_half) begin
      be_d    = addr[1] ? 4'b1100 : 4'b0011;
      lanes_d = {2{wdata[15:0]}};
    end else if (!is_word) begin
      be_d    = 4'b0001 << addr[1:0];
      lanes_d = {4{wdata[7:0]}};
    end
  end

  // Extraction uses the offset/size latched at request time, not the live inputs.
  always_comb begin
    ld_b   = bus.rdata[{off_q, 3'b000} +: 8];
    ld_h   = bus.rdata[{off_q[1], 4'b0000} +: 16];
    ld_ext = bus.rdata;
    if (size_q == 2'b00)      ld_ext = {{24{~uns_q & ld_b[7]}}, ld_b};
    else if (size_q == 2'b01) ld_ext = {{16{~uns_q & ld_h[15]}}, ld_h};
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = BUSY;
      BUSY:    if (bus.ack || tmo) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    misaligned = access & ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));
    stall      = go & (state_q != DONE);
    rdata      = (state_q == DONE) ? rdata_q : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      baddr_q  <= 32'h0;
      bwdata_q <= 32'h0;
      be_q     <= 4'h0;
      rdata_q  <= 32'h0;
      cnt_q    <= 8'h0;
      off_q    <= 2'b00;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          err_q <= 1'b0;
          if (go) begin
            req_q    <= 1'b1;
            we_q     <= mem_write;
            baddr_q  <= {addr[31:2], 2'b00};
            bwdata_q <= lanes_d;
            be_q     <= be_d;
            off_q    <= addr[1:0];
            size_q   <= funct3[1:0];
            uns_q    <= funct3[2];
            cnt_q    <= 8'h0;
          end
        end
        BUSY: begin
          // An ack on the expiry cycle still completes the access normally.
          if (bus.ack) begin
            req_q   <= 1'b0;
            rdata_q <= we_q ? 32'h0 : ld_ext;
          end else if (tmo) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 8'h1;
          end
        end
        default: err_q <= 1'b0;
      endcase
    end
  end

  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.addr  = baddr_q;
  assign bus.wdata = bwdata_q;
  assign bus.be    = be_q;
  assign bus_err   = err_q;

endmodule
